// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer and its opcode decoder.
//   op_dir_e     : shift/rotate direction, shared with the ALU
//   OPC_*        : instruction opcode encodings (instr[7:5])
//   OP_*         : bit positions of the one-hot op strobe vector
//   seq_state_e  : sequencer FSM states
package alu_sequencer_pkg;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } op_dir_e;

    localparam logic [2:0] OPC_NOP     = 3'b000;
    localparam logic [2:0] OPC_ADD     = 3'b001;
    localparam logic [2:0] OPC_SUB     = 3'b010;
    localparam logic [2:0] OPC_MUL     = 3'b011;
    localparam logic [2:0] OPC_DIV     = 3'b100;
    localparam logic [2:0] OPC_SHIFT   = 3'b101;
    localparam logic [2:0] OPC_ROT     = 3'b110;
    localparam logic [2:0] OPC_ILLEGAL = 3'b111;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_MUL   = 2;
    localparam int unsigned OP_DIV   = 3;
    localparam int unsigned OP_SHIFT = 4;
    localparam int unsigned OP_ROT   = 5;
    localparam int unsigned NUM_OPS  = 6;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StWb,
        StFin
    } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
//   opcode_i     : instr[7:5]
//   dir_i        : instr[4], 0 = LEFT, 1 = RIGHT
//   op_vec_o     : one-hot ALU op vector (bit positions OP_*), all zero for NOP/ILLEGAL
//   op_dir_o     : direction, only RIGHT for SHIFT/ROT with dir_i set
//   is_illegal_o : opcode 111
//   is_nop_o     : opcode 000
//   is_div_o     : opcode 100
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [2:0]         opcode_i,
    input  logic               dir_i,
    output logic [NUM_OPS-1:0] op_vec_o,
    output op_dir_e            op_dir_o,
    output logic               is_illegal_o,
    output logic               is_nop_o,
    output logic               is_div_o
);

    always_comb begin
        op_vec_o     = '0;
        op_dir_o     = LEFT;
        is_illegal_o = 1'b0;
        is_nop_o     = 1'b0;
        is_div_o     = 1'b0;
        unique case (opcode_i)
            OPC_NOP:   is_nop_o = 1'b1;
            OPC_ADD:   op_vec_o[OP_ADD] = 1'b1;
            OPC_SUB:   op_vec_o[OP_SUB] = 1'b1;
            OPC_MUL:   op_vec_o[OP_MUL] = 1'b1;
            OPC_DIV: begin
                op_vec_o[OP_DIV] = 1'b1;
                is_div_o         = 1'b1;
            end
            OPC_SHIFT: begin
                op_vec_o[OP_SHIFT] = 1'b1;
                op_dir_o           = dir_i ? RIGHT : LEFT;
            end
            OPC_ROT: begin
                op_vec_o[OP_ROT] = 1'b1;
                op_dir_o         = dir_i ? RIGHT : LEFT;
            end
            OPC_ILLEGAL: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issuing side of the ALU control interface. Accepts one instruction byte per
// valid/ready transaction, drives the ALU enable and one-hot op strobes for
// EXEC_CYCLES cycles, then pulses write-back and done (or done+fault).
//   clock, reset            : clock and asynchronous active-high reset
//   instr_valid/instr_ready : instruction handshake, ready only in IDLE
//   instr                   : [7:5] opcode, [4] dir, [3:2] dst, [1:0] src
//   divisor_zero            : register2 == 0, sampled in DECODE
//   src_sel, dst_sel        : latched operand / destination register selects
//   out, op_*, op_dir       : ALU enable, one-hot op strobes, direction
//   wb_en, done, fault      : write-back strobe, completion pulse, fault qualifier
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES   = 1,
    parameter bit          FAULT_ON_DIV0 = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic       divisor_zero,
    output logic [1:0] src_sel,
    output logic       out,
    output logic       op_add,
    output logic       op_sub,
    output logic       op_mul,
    output logic       op_div,
    output logic       op_shift,
    output logic       op_rot,
    output op_dir_e    op_dir,
    output logic       wb_en,
    output logic [1:0] dst_sel,
    output logic       done,
    output logic       fault
);

    seq_state_e   state_q, state_d;
    logic [7:0]   instr_q, instr_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         fault_q, fault_d;

    logic [NUM_OPS-1:0] op_vec;
    op_dir_e            dec_dir;
    logic               is_illegal;
    logic               is_nop;
    logic               is_div;

    alu_op_decode u_decode (
        .opcode_i     (instr_q[7:5]),
        .dir_i        (instr_q[4]),
        .op_vec_o     (op_vec),
        .op_dir_o     (dec_dir),
        .is_illegal_o (is_illegal),
        .is_nop_o     (is_nop),
        .is_div_o     (is_div)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_illegal) begin
                    fault_d = 1'b1;
                    state_d = StFin;
                end else if (is_nop) begin
                    fault_d = 1'b0;
                    state_d = StFin;
                end else if (is_div && divisor_zero && FAULT_ON_DIV0) begin
                    fault_d = 1'b1;
                    state_d = StFin;
                end else begin
                    fault_d = 1'b0;
                    cnt_d   = 4'(EXEC_CYCLES - 1);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWb:    state_d = StIdle;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            instr_q <= 8'h00;
            cnt_q   <= 4'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Moore outputs; strobes and direction are gated by EXEC so reset drops them at once.
    logic exec_active;

    always_comb begin
        exec_active = (state_q == StExec);
        instr_ready = (state_q == StIdle);
        src_sel     = instr_q[1:0];
        dst_sel     = instr_q[3:2];
        out         = exec_active;
        op_add      = exec_active & op_vec[OP_ADD];
        op_sub      = exec_active & op_vec[OP_SUB];
        op_mul      = exec_active & op_vec[OP_MUL];
        op_div      = exec_active & op_vec[OP_DIV];
        op_shift    = exec_active & op_vec[OP_SHIFT];
        op_rot      = exec_active & op_vec[OP_ROT];
        op_dir      = exec_active ? dec_dir : LEFT;
        wb_en       = (state_q == StWb);
        done        = (state_q == StWb) || (state_q == StFin);
        fault       = (state_q == StFin) && fault_q;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. Two instances share stimulus: index 0 uses
// EXEC_CYCLES=1, index 1 uses EXEC_CYCLES=3. Each transaction is traced per
// cycle after the accept edge (k=1 is DECODE) and compared to hand-derived values.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       divisor_zero = 1'b0;

    logic [1:0] rdy_w, out_w, add_w, sub_w, mul_w, div_w, shift_w, rot_w;
    logic [1:0] wb_w, done_w, fault_w;
    logic [1:0] src_w [2];
    logic [1:0] dst_w [2];
    op_dir_e    dir_w [2];
    logic [5:0] ops_w [2];

    always #5 clock = ~clock;

    alu_sequencer #(.EXEC_CYCLES(1), .FAULT_ON_DIV0(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy_w[0]),
        .instr(instr), .divisor_zero(divisor_zero), .src_sel(src_w[0]), .out(out_w[0]),
        .op_add(add_w[0]), .op_sub(sub_w[0]), .op_mul(mul_w[0]), .op_div(div_w[0]),
        .op_shift(shift_w[0]), .op_rot(rot_w[0]), .op_dir(dir_w[0]), .wb_en(wb_w[0]),
        .dst_sel(dst_w[0]), .done(done_w[0]), .fault(fault_w[0])
    );

    alu_sequencer #(.EXEC_CYCLES(3), .FAULT_ON_DIV0(1'b1)) u_dut3 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy_w[1]),
        .instr(instr), .divisor_zero(divisor_zero), .src_sel(src_w[1]), .out(out_w[1]),
        .op_add(add_w[1]), .op_sub(sub_w[1]), .op_mul(mul_w[1]), .op_div(div_w[1]),
        .op_shift(shift_w[1]), .op_rot(rot_w[1]), .op_dir(dir_w[1]), .wb_en(wb_w[1]),
        .dst_sel(dst_w[1]), .done(done_w[1]), .fault(fault_w[1])
    );

    assign ops_w[0] = {rot_w[0], shift_w[0], div_w[0], mul_w[0], sub_w[0], add_w[0]};
    assign ops_w[1] = {rot_w[1], shift_w[1], div_w[1], mul_w[1], sub_w[1], add_w[1]};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle trace, index k = cycles after the accept edge.
    logic [15:0] t_out, t_done, t_wb, t_fault, t_rdy;
    logic [5:0]  t_ops [16];
    logic [1:0]  t_src [16];
    logic [1:0]  t_dst [16];
    op_dir_e     t_dir [16];

    // Call just after a posedge; returns on the negedge of cycle ncyc.
    task automatic run(input string tag, input int sel, input logic [7:0] ins, input logic dz,
                       input bit hold, input int ncyc);
        check({tag, "_ready_before"}, rdy_w[sel], 1'b1);
        instr_valid  = 1'b1;
        instr        = ins;
        divisor_zero = dz;
        @(posedge clock);
        #1;
        if (!hold) instr_valid = 1'b0;
        t_out = '0; t_done = '0; t_wb = '0; t_fault = '0; t_rdy = '0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            t_out[k]   = out_w[sel];
            t_done[k]  = done_w[sel];
            t_wb[k]    = wb_w[sel];
            t_fault[k] = fault_w[sel];
            t_rdy[k]   = rdy_w[sel];
            t_ops[k]   = ops_w[sel];
            t_src[k]   = src_w[sel];
            t_dst[k]   = dst_w[sel];
            t_dir[k]   = dir_w[sel];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Invariants and done-per-accept tracking, sampled mid-cycle.
    bit pending [2];
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            check("inv_onehot", $countones(ops_w[d]) <= 1, 1'b1);
            check("inv_strobe_wo_out", (ops_w[d] != 6'd0) && !out_w[d], 1'b0);
            check("inv_wb_and_fault", wb_w[d] & fault_w[d], 1'b0);
            if (reset) begin
                pending[d] = 1'b0;
            end else begin
                if (done_w[d]) begin
                    check("done_without_accept", pending[d], 1'b1);
                    pending[d] = 1'b0;
                end
                if (instr_valid && rdy_w[d]) pending[d] = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done, n_wb;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", rdy_w[d], 1'b1);
            check("rst_out", out_w[d], 1'b0);
            check("rst_ops", ops_w[d], 6'd0);
            check("rst_wb", wb_w[d], 1'b0);
            check("rst_done", done_w[d], 1'b0);
            check("rst_fault", fault_w[d], 1'b0);
            check("rst_dir", dir_w[d], LEFT);
            check("rst_src", src_w[d], 2'b00);
            check("rst_dst", dst_w[d], 2'b00);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        idle(1);

        // ADD: src=01 dst=10, done on k=3
        run("add", 0, 8'b001_0_10_01, 1'b0, 1'b0, 6);
        check("add_rdy_decode", t_rdy[1], 1'b0);
        check("add_out1", t_out[1], 1'b0);
        check("add_out2", t_out[2], 1'b1);
        check("add_ops2", t_ops[2], 6'b000001);
        check("add_src2", t_src[2], 2'b01);
        check("add_out3", t_out[3], 1'b0);
        check("add_wb3", t_wb[3], 1'b1);
        check("add_dst3", t_dst[3], 2'b10);
        check("add_done3", t_done[3], 1'b1);
        check("add_fault3", t_fault[3], 1'b0);
        check("add_rdy3", t_rdy[3], 1'b0);
        check("add_rdy4", t_rdy[4], 1'b1);
        check("add_ndone", $countones(t_done), 1);
        check("add_nout", $countones(t_out), 1);
        idle(8);

        // ROT right
        run("rot", 0, 8'b110_1_00_00, 1'b0, 1'b0, 6);
        check("rot_ops2", t_ops[2], 6'b100000);
        check("rot_dir2", t_dir[2], RIGHT);
        check("rot_dir3", t_dir[3], LEFT);
        check("rot_wb3", t_wb[3], 1'b1);
        check("rot_done3", t_done[3], 1'b1);
        idle(8);

        // SUB with dir bit set still reports LEFT
        run("sub", 0, 8'b010_1_11_10, 1'b0, 1'b0, 6);
        check("sub_ops2", t_ops[2], 6'b000010);
        check("sub_dir2", t_dir[2], LEFT);
        check("sub_src2", t_src[2], 2'b10);
        check("sub_dst3", t_dst[3], 2'b11);
        idle(8);

        // SHIFT right
        run("shr", 0, 8'b101_1_01_11, 1'b0, 1'b0, 6);
        check("shr_ops2", t_ops[2], 6'b010000);
        check("shr_dir2", t_dir[2], RIGHT);
        idle(8);

        // DIV with zero divisor faults at k=2
        run("div0", 0, 8'b100_0_01_00, 1'b1, 1'b0, 6);
        check("div0_nout", $countones(t_out), 0);
        check("div0_nwb", $countones(t_wb), 0);
        check("div0_done1", t_done[1], 1'b0);
        check("div0_done2", t_done[2], 1'b1);
        check("div0_fault2", t_fault[2], 1'b1);
        check("div0_rdy3", t_rdy[3], 1'b1);
        idle(8);

        // DIV with nonzero divisor issues normally
        run("div", 0, 8'b100_0_01_00, 1'b0, 1'b0, 6);
        check("div_ops2", t_ops[2], 6'b001000);
        check("div_wb3", t_wb[3], 1'b1);
        check("div_fault3", t_fault[3], 1'b0);
        idle(8);
        divisor_zero = 1'b0;

        // Illegal opcode
        run("ill", 0, 8'hE0, 1'b0, 1'b0, 6);
        check("ill_done2", t_done[2], 1'b1);
        check("ill_fault2", t_fault[2], 1'b1);
        check("ill_nout", $countones(t_out), 0);
        check("ill_nwb", $countones(t_wb), 0);
        idle(8);

        // NOP
        run("nop", 0, 8'h00, 1'b0, 1'b0, 6);
        check("nop_done2", t_done[2], 1'b1);
        check("nop_fault2", t_fault[2], 1'b0);
        check("nop_nout", $countones(t_out), 0);
        check("nop_nwb", $countones(t_wb), 0);
        idle(8);

        // EXEC_CYCLES=3 MUL: EXEC k=2..4, done k=5
        run("mul3", 1, 8'b011_0_01_10, 1'b0, 1'b0, 7);
        for (int k = 2; k <= 4; k++) begin
            check("mul3_out", t_out[k], 1'b1);
            check("mul3_ops", t_ops[k], 6'b000100);
            check("mul3_src", t_src[k], 2'b10);
        end
        check("mul3_out5", t_out[5], 1'b0);
        check("mul3_done4", t_done[4], 1'b0);
        check("mul3_done5", t_done[5], 1'b1);
        check("mul3_wb5", t_wb[5], 1'b1);
        check("mul3_dst5", t_dst[5], 2'b01);
        check("mul3_ndone", $countones(t_done), 1);
        idle(8);

        // Valid held high: second accept in the cycle after done
        run("b2b", 1, 8'b011_0_00_01, 1'b0, 1'b1, 12);
        check("b2b_rdy5", t_rdy[5], 1'b0);
        check("b2b_done5", t_done[5], 1'b1);
        check("b2b_rdy6", t_rdy[6], 1'b1);
        check("b2b_rdy7", t_rdy[7], 1'b0);
        check("b2b_out8", t_out[8], 1'b1);
        check("b2b_done11", t_done[11], 1'b1);
        check("b2b_ndone", $countones(t_done), 2);
        idle(1);
        instr_valid = 1'b0;
        idle(8);

        // Reset during EXEC
        run("rst", 1, 8'b011_0_00_01, 1'b0, 1'b0, 2);
        check("rst_exec_out", t_out[2], 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_out", out_w[1], 1'b0);
        check("rst_mid_ops", ops_w[1], 6'd0);
        check("rst_mid_out_d1", out_w[0], 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        n_done = 0;
        n_wb   = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            n_done += int'(done_w[0]) + int'(done_w[1]);
            n_wb   += int'(wb_w[0]) + int'(wb_w[1]);
        end
        check("rst_after_rdy", rdy_w[1], 1'b1);
        check("rst_after_ndone", n_done, 0);
        check("rst_after_nwb", n_wb, 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
